// File: rtl/olo_axi_slave_mem_pkg.sv
// Shared constants for the AXI4 slave memory: response codes,
// burst encodings and FSM state encodings.
package olo_axi_slave_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef logic [1:0] wstate_t;
    localparam wstate_t W_IDLE = 2'd0;
    localparam wstate_t W_DATA = 2'd1;
    localparam wstate_t W_RESP = 2'd2;

    typedef logic [1:0] rstate_t;
    localparam rstate_t R_IDLE = 2'd0;
    localparam rstate_t R_WAIT = 2'd1;
    localparam rstate_t R_DATA = 2'd2;

    // WRAP and the reserved encoding are not served.
    function automatic logic burst_bad(input logic [1:0] burst);
        return (burst == BURST_WRAP) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/olo_axi_slave_mem_ram.sv
// Word-wide RAM: one byte-enabled write port, one registered read port.
// Read returns the old word when read and write hit the same address.
module olo_axi_slave_mem_ram #(
    parameter int DataWidth_g = 32,
    parameter int Depth_g     = 1024
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       wr_en,
    input  logic [$clog2(Depth_g)-1:0] wr_addr,
    input  logic [DataWidth_g/8-1:0]   wr_be,
    input  logic [DataWidth_g-1:0]     wr_data,
    input  logic                       rd_en,
    input  logic [$clog2(Depth_g)-1:0] rd_addr,
    output logic [DataWidth_g-1:0]     rd_data
);

    logic [DataWidth_g-1:0] mem [Depth_g];

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            for (int b = 0; b < DataWidth_g/8; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/olo_axi_slave_mem.sv
// AXI4 slave backed by an on-chip RAM with independent read and write
// channels, configurable read latency and a SLVERR address window.
module olo_axi_slave_mem
    import olo_axi_slave_mem_pkg::*;
#(
    parameter int                        AxiAddrWidth_g = 32,
    parameter int                        AxiDataWidth_g = 32,
    parameter int                        MemDepth_g     = 1024,
    parameter int                        RdLatency_g    = 2,
    parameter logic [AxiAddrWidth_g-1:0] ErrAddrLo_g    = 'hFFFF0000,
    parameter logic [AxiAddrWidth_g-1:0] ErrAddrHi_g    = 'hFFFFFFFF
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [AxiAddrWidth_g-1:0]   S_Axi_AwAddr,
    input  logic [7:0]                  S_Axi_AwLen,
    input  logic [2:0]                  S_Axi_AwSize,
    input  logic [1:0]                  S_Axi_AwBurst,
    input  logic                        S_Axi_AwValid,
    output logic                        S_Axi_AwReady,
    input  logic [AxiDataWidth_g-1:0]   S_Axi_WData,
    input  logic [AxiDataWidth_g/8-1:0] S_Axi_WStrb,
    input  logic                        S_Axi_WLast,
    input  logic                        S_Axi_WValid,
    output logic                        S_Axi_WReady,
    output logic [1:0]                  S_Axi_BResp,
    output logic                        S_Axi_BValid,
    input  logic                        S_Axi_BReady,
    input  logic [AxiAddrWidth_g-1:0]   S_Axi_ArAddr,
    input  logic [7:0]                  S_Axi_ArLen,
    input  logic [2:0]                  S_Axi_ArSize,
    input  logic [1:0]                  S_Axi_ArBurst,
    input  logic                        S_Axi_ArValid,
    output logic                        S_Axi_ArReady,
    output logic [AxiDataWidth_g-1:0]   S_Axi_RData,
    output logic [1:0]                  S_Axi_RResp,
    output logic                        S_Axi_RLast,
    output logic                        S_Axi_RValid,
    input  logic                        S_Axi_RReady
);

    localparam int         ByteBits = $clog2(AxiDataWidth_g/8);
    localparam int         WordBits = $clog2(MemDepth_g);
    localparam logic [2:0] SizeOk   = 3'(ByteBits);
    localparam logic [3:0] LatLast  = 4'(RdLatency_g > 0 ? RdLatency_g - 1 : 0);

    typedef logic [WordBits-1:0] word_t;

    // Ready outputs stay low until the first clock after reset release.
    logic live_q;

    wstate_t    w_state_q, w_state_d;
    word_t      w_word_q, w_word_d;
    logic [7:0] w_cnt_q, w_cnt_d, w_len_q, w_len_d;
    logic [1:0] w_burst_q, w_burst_d, bresp_q, bresp_d;
    logic       w_err_q, w_err_d, mem_we;

    rstate_t    r_state_q, r_state_d;
    word_t      r_word_q, r_word_d, rd_addr, r_next;
    logic [7:0] r_cnt_q, r_cnt_d, r_len_q, r_len_d;
    logic [3:0] r_lat_q, r_lat_d;
    logic [1:0] r_burst_q, r_burst_d;
    logic       r_err_q, r_err_d, rd_en;

    logic [AxiDataWidth_g-1:0] ram_q;
    logic aw_err, ar_err;

    assign aw_err = (S_Axi_AwSize != SizeOk) || burst_bad(S_Axi_AwBurst)
                 || (S_Axi_AwAddr >= ErrAddrLo_g && S_Axi_AwAddr <= ErrAddrHi_g);
    assign ar_err = (S_Axi_ArSize != SizeOk) || burst_bad(S_Axi_ArBurst)
                 || (S_Axi_ArAddr >= ErrAddrLo_g && S_Axi_ArAddr <= ErrAddrHi_g);

    always_comb begin
        w_state_d = w_state_q;
        w_word_d  = w_word_q;
        w_cnt_d   = w_cnt_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (S_Axi_AwValid && live_q) begin
                    w_word_d  = S_Axi_AwAddr[ByteBits +: WordBits];
                    w_len_d   = S_Axi_AwLen;
                    w_burst_d = S_Axi_AwBurst;
                    w_err_d   = aw_err;
                    w_cnt_d   = 8'd0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (S_Axi_WValid) begin
                    mem_we = !w_err_q;
                    if (w_burst_q == BURST_INCR) begin
                        w_word_d = w_word_q + 1'b1;
                    end
                    if (S_Axi_WLast) begin
                        bresp_d   = (w_err_q || w_cnt_q != w_len_q) ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (S_Axi_BReady) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign r_next = (r_burst_q == BURST_INCR) ? r_word_q + 1'b1 : r_word_q;

    // The RAM read is issued on the edge that enters R_DATA, so the
    // registered RAM output is already valid when RValid rises.
    always_comb begin
        r_state_d = r_state_q;
        r_word_d  = r_word_q;
        r_cnt_d   = r_cnt_q;
        r_len_d   = r_len_q;
        r_lat_d   = r_lat_q;
        r_burst_d = r_burst_q;
        r_err_d   = r_err_q;
        rd_en     = 1'b0;
        rd_addr   = r_word_q;
        unique case (r_state_q)
            R_IDLE: begin
                rd_addr = S_Axi_ArAddr[ByteBits +: WordBits];
                if (S_Axi_ArValid && live_q) begin
                    r_word_d  = rd_addr;
                    r_len_d   = S_Axi_ArLen;
                    r_burst_d = S_Axi_ArBurst;
                    r_err_d   = ar_err;
                    r_cnt_d   = 8'd0;
                    r_lat_d   = 4'd0;
                    if (RdLatency_g == 0) begin
                        rd_en     = 1'b1;
                        r_state_d = R_DATA;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_lat_q == LatLast) begin
                    rd_en     = 1'b1;
                    r_state_d = R_DATA;
                end else begin
                    r_lat_d = r_lat_q + 4'd1;
                end
            end
            R_DATA: begin
                if (S_Axi_RReady) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        rd_addr  = r_next;
                        r_word_d = r_next;
                        rd_en    = 1'b1;
                        r_cnt_d  = r_cnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            w_word_q  <= '0;
            w_cnt_q   <= '0;
            w_len_q   <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            r_word_q  <= '0;
            r_cnt_q   <= '0;
            r_len_q   <= '0;
            r_lat_q   <= '0;
            r_burst_q <= '0;
            r_err_q   <= 1'b0;
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            w_word_q  <= w_word_d;
            w_cnt_q   <= w_cnt_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            r_word_q  <= r_word_d;
            r_cnt_q   <= r_cnt_d;
            r_len_q   <= r_len_d;
            r_lat_q   <= r_lat_d;
            r_burst_q <= r_burst_d;
            r_err_q   <= r_err_d;
        end
    end

    olo_axi_slave_mem_ram #(
        .DataWidth_g(AxiDataWidth_g),
        .Depth_g    (MemDepth_g)
    ) u_ram (
        .Clk    (Clk),
        .Rst    (Rst),
        .wr_en  (mem_we),
        .wr_addr(w_word_q),
        .wr_be  (S_Axi_WStrb),
        .wr_data(S_Axi_WData),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(ram_q)
    );

    assign S_Axi_AwReady = live_q && (w_state_q == W_IDLE);
    assign S_Axi_WReady  = (w_state_q == W_DATA);
    assign S_Axi_BValid  = (w_state_q == W_RESP);
    assign S_Axi_BResp   = bresp_q;
    assign S_Axi_ArReady = live_q && (r_state_q == R_IDLE);
    assign S_Axi_RValid  = (r_state_q == R_DATA);
    assign S_Axi_RLast   = S_Axi_RValid && (r_cnt_q == r_len_q);
    assign S_Axi_RResp   = r_err_q ? RESP_SLVERR : RESP_OKAY;
    assign S_Axi_RData   = r_err_q ? '0 : ram_q;

endmodule

// File: tb/tb_olo_axi_slave_mem.sv
// Directed bench for olo_axi_slave_mem: write/read bursts, strobes,
// error responses, read stalls and reset in the middle of a read burst.
module tb_olo_axi_slave_mem;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] AwAddr = '0;
    logic [7:0]  AwLen = '0;
    logic [2:0]  AwSize = 3'd2;
    logic [1:0]  AwBurst = 2'b01;
    logic        AwValid = 1'b0;
    logic        AwReady;
    logic [31:0] WData = '0;
    logic [3:0]  WStrb = '0;
    logic        WLast = 1'b0;
    logic        WValid = 1'b0;
    logic        WReady;
    logic [1:0]  BResp;
    logic        BValid;
    logic        BReady = 1'b0;
    logic [31:0] ArAddr = '0;
    logic [7:0]  ArLen = '0;
    logic [2:0]  ArSize = 3'd2;
    logic [1:0]  ArBurst = 2'b01;
    logic        ArValid = 1'b0;
    logic        ArReady;
    logic [31:0] RData;
    logic [1:0]  RResp;
    logic        RLast;
    logic        RValid;
    logic        RReady = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int tmo = 0;

    logic [31:0] wdat [8];
    logic [31:0] rdat [8];
    logic        rlst [8];
    logic [1:0]  rrsp [8];

    always #5 Clk = ~Clk;

    olo_axi_slave_mem #(
        .AxiAddrWidth_g(32),
        .AxiDataWidth_g(32),
        .MemDepth_g    (1024),
        .RdLatency_g   (2),
        .ErrAddrLo_g   (32'hFFFF0000),
        .ErrAddrHi_g   (32'hFFFFFFFF)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .S_Axi_AwAddr (AwAddr),
        .S_Axi_AwLen  (AwLen),
        .S_Axi_AwSize (AwSize),
        .S_Axi_AwBurst(AwBurst),
        .S_Axi_AwValid(AwValid),
        .S_Axi_AwReady(AwReady),
        .S_Axi_WData  (WData),
        .S_Axi_WStrb  (WStrb),
        .S_Axi_WLast  (WLast),
        .S_Axi_WValid (WValid),
        .S_Axi_WReady (WReady),
        .S_Axi_BResp  (BResp),
        .S_Axi_BValid (BValid),
        .S_Axi_BReady (BReady),
        .S_Axi_ArAddr (ArAddr),
        .S_Axi_ArLen  (ArLen),
        .S_Axi_ArSize (ArSize),
        .S_Axi_ArBurst(ArBurst),
        .S_Axi_ArValid(ArValid),
        .S_Axi_ArReady(ArReady),
        .S_Axi_RData  (RData),
        .S_Axi_RResp  (RResp),
        .S_Axi_RLast  (RLast),
        .S_Axi_RValid (RValid),
        .S_Axi_RReady (RReady)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] sz, input logic [1:0] bu,
                             input logic [3:0] strb, input int last_at,
                             output logic [1:0] resp);
        int n;
        AwAddr = a; AwLen = len; AwSize = sz; AwBurst = bu; AwValid = 1'b1;
        n = 0;
        while (!AwReady && n < 50) begin step(); n++; end
        if (n >= 50) tmo++;
        step();
        AwValid = 1'b0;
        for (int i = 0; i <= last_at; i++) begin
            WData = wdat[i]; WStrb = strb; WLast = (i == last_at); WValid = 1'b1;
            n = 0;
            while (!WReady && n < 50) begin step(); n++; end
            if (n >= 50) tmo++;
            step();
        end
        WValid = 1'b0; WLast = 1'b0;
        BReady = 1'b1;
        n = 0;
        while (!BValid && n < 50) begin step(); n++; end
        if (n >= 50) tmo++;
        resp = BResp;
        step();
        BReady = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bu,
                            input bit toggle, output int lat, output int stall_bad);
        int n, beat;
        bit rr, held;
        logic [34:0] snap;
        ArAddr = a; ArLen = len; ArSize = sz; ArBurst = bu; ArValid = 1'b1;
        n = 0;
        while (!ArReady && n < 50) begin step(); n++; end
        if (n >= 50) tmo++;
        step();
        ArValid = 1'b0;
        lat = 0;
        while (!RValid && lat < 50) begin step(); lat++; end
        if (lat >= 50) tmo++;
        beat = 0; rr = !toggle; held = 1'b0; stall_bad = 0; snap = '0; n = 0;
        while (beat <= int'(len) && n < 2000) begin
            RReady = rr;
            if (held && {RData, RLast, RResp} !== snap) stall_bad++;
            held = 1'b0;
            if (RValid && rr) begin
                rdat[beat] = RData; rlst[beat] = RLast; rrsp[beat] = RResp;
                beat++;
            end else if (RValid) begin
                snap = {RData, RLast, RResp};
                held = 1'b1;
            end
            step();
            n++;
            if (toggle) rr = !rr;
        end
        if (n >= 2000) tmo++;
        RReady = 1'b0;
    endtask

    initial begin
        logic [1:0] resp;
        int lat, sb, n;

        step();
        check("rst_awready", 32'(AwReady), 32'd0);
        check("rst_arready", 32'(ArReady), 32'd0);
        check("rst_bvalid", 32'(BValid), 32'd0);
        check("rst_rvalid", 32'(RValid), 32'd0);
        check("rst_rlast", 32'(RLast), 32'd0);
        check("rst_bresp", 32'(BResp), 32'd0);
        check("rst_rresp", 32'(RResp), 32'd0);
        check("rst_rdata", RData, 32'd0);
        step();
        Rst = 1'b0;
        step();

        // Single beat write and read, latency 2
        wdat[0] = 32'hABCDEF01;
        axi_write(32'h1000, 8'd0, 3'd2, 2'b01, 4'hF, 0, resp);
        check("single_bresp", 32'(resp), 32'd0);
        axi_read(32'h1000, 8'd0, 3'd2, 2'b01, 1'b0, lat, sb);
        check("single_rdata", rdat[0], 32'hABCDEF01);
        check("single_rlast", 32'(rlst[0]), 32'd1);
        check("single_rresp", 32'(rrsp[0]), 32'd0);
        check("single_lat", 32'(lat), 32'd2);

        // INCR burst, read back with RReady toggling
        for (int i = 0; i < 4; i++) wdat[i] = 32'hA000 + 32'(i);
        axi_write(32'h3000, 8'd3, 3'd2, 2'b01, 4'hF, 3, resp);
        check("incr_bresp", 32'(resp), 32'd0);
        axi_read(32'h3000, 8'd3, 3'd2, 2'b01, 1'b1, lat, sb);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("incr_rdata%0d", i), rdat[i], 32'hA000 + 32'(i));
            check($sformatf("incr_rlast%0d", i), 32'(rlst[i]), 32'(i == 3));
        end
        check("incr_stall_stable", 32'(sb), 32'd0);

        // FIXED burst lands all beats on one word
        for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
        axi_write(32'h4000, 8'd3, 3'd2, 2'b00, 4'hF, 3, resp);
        check("fixed_bresp", 32'(resp), 32'd0);
        axi_read(32'h4000, 8'd0, 3'd2, 2'b01, 1'b0, lat, sb);
        check("fixed_rdata", rdat[0], 32'd4);
        axi_read(32'h3004, 8'd0, 3'd2, 2'b01, 1'b0, lat, sb);
        check("fixed_neighbour", rdat[0], 32'hA001);

        // Partial strobe
        wdat[0] = 32'h11223344;
        axi_write(32'h2000, 8'd0, 3'd2, 2'b01, 4'hF, 0, resp);
        wdat[0] = 32'hFFFFFFFF;
        axi_write(32'h2000, 8'd0, 3'd2, 2'b01, 4'h3, 0, resp);
        axi_read(32'h2000, 8'd0, 3'd2, 2'b01, 1'b0, lat, sb);
        check("strb_rdata", rdat[0], 32'h1122FFFF);

        // Error window, WRAP and bad size: SLVERR and no memory change
        wdat[0] = 32'h55AA55AA;
        axi_write(32'h0010, 8'd0, 3'd2, 2'b01, 4'hF, 0, resp);
        wdat[0] = 32'hDEADBEEF; wdat[1] = 32'hDEADBEEF;
        axi_write(32'hFFFF0010, 8'd0, 3'd2, 2'b01, 4'hF, 0, resp);
        check("win_bresp", 32'(resp), 32'd2);
        axi_write(32'h0010, 8'd1, 3'd2, 2'b10, 4'hF, 1, resp);
        check("wrap_bresp", 32'(resp), 32'd2);
        axi_write(32'h0010, 8'd0, 3'd1, 2'b01, 4'hF, 0, resp);
        check("size_bresp", 32'(resp), 32'd2);
        axi_read(32'h0010, 8'd0, 3'd2, 2'b01, 1'b0, lat, sb);
        check("err_unchanged", rdat[0], 32'h55AA55AA);
        check("err_unchanged_rresp", 32'(rrsp[0]), 32'd0);
        axi_read(32'hFFFF0010, 8'd0, 3'd2, 2'b01, 1'b0, lat, sb);
        check("win_rresp", 32'(rrsp[0]), 32'd2);
        check("win_rdata", rdat[0], 32'd0);
        check("win_rlast", 32'(rlst[0]), 32'd1);

        // Early WLast
        axi_write(32'h0020, 8'd3, 3'd2, 2'b01, 4'hF, 1, resp);
        check("early_wlast_bresp", 32'(resp), 32'd2);

        // Reset during beat 2 of a read burst
        ArAddr = 32'h3000; ArLen = 8'd3; ArSize = 3'd2; ArBurst = 2'b01; ArValid = 1'b1;
        n = 0;
        while (!ArReady && n < 50) begin step(); n++; end
        if (n >= 50) tmo++;
        step();
        ArValid = 1'b0;
        RReady = 1'b1;
        n = 0;
        while (!RValid && n < 50) begin step(); n++; end
        if (n >= 50) tmo++;
        step();
        step();
        check("mid_beat2_rdata", RData, 32'hA002);
        check("mid_beat2_rvalid", 32'(RValid), 32'd1);
        Rst = 1'b1;
        #1;
        check("mid_rst_rvalid", 32'(RValid), 32'd0);
        check("mid_rst_rlast", 32'(RLast), 32'd0);
        check("mid_rst_rdata", RData, 32'd0);
        check("mid_rst_arready", 32'(ArReady), 32'd0);
        RReady = 1'b0;
        step();
        Rst = 1'b0;
        step();
        check("post_rst_arready", 32'(ArReady), 32'd1);
        check("post_rst_awready", 32'(AwReady), 32'd1);
        axi_read(32'h3008, 8'd0, 3'd2, 2'b01, 1'b0, lat, sb);
        check("post_rst_mem2", rdat[0], 32'hA002);
        axi_read(32'h0010, 8'd0, 3'd2, 2'b01, 1'b0, lat, sb);
        check("post_rst_mem4", rdat[0], 32'h55AA55AA);
        axi_read(32'h2000, 8'd0, 3'd2, 2'b01, 1'b0, lat, sb);
        check("post_rst_mem0", rdat[0], 32'h1122FFFF);

        check("timeouts", 32'(tmo), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
